branch_predictor: RTL and testbench

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits in the IF stage. It predicts taken/target for the fetch PC.
- The EX-stage branch resolution unit writes back resolved outcomes (taken, jump, target) through the update port.
- It also flags mispredictions and supplies the redirect PC to the PC mux.

---
 rtl/branch_predictor.sv | 152 +++++++++++++++
 tb/tb_branch_predictor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Optional macro BP_STATS_EN adds update/mispredict event counters.
module branch_predictor #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
   ,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = XLEN - IDX_W - 2;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [XLEN-1:0]  target_q [DEPTH];
   logic             jump_q   [DEPTH];
   logic [1:0]       cnt_q    [DEPTH];

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_hit;
   logic             unused_pc_bits;

   assign rd_idx         = if_pc[IDX_W+1:2];
   assign rd_tag         = if_pc[XLEN-1:IDX_W+2];
   assign rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign pred_taken     = rd_hit && (jump_q[rd_idx] || cnt_q[rd_idx][1]);
   assign pred_target    = pred_taken ? target_q[rd_idx] : '0;
   assign unused_pc_bits = ^if_pc[1:0];

   // ---------------- update ----------------
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_hit;
   logic             wr_en;
   logic [XLEN-1:0]  wr_target_d;
   logic             wr_jump_d;
   logic [1:0]       wr_cnt_d;

   assign wr_idx = upd_pc[IDX_W+1:2];
   assign wr_tag = upd_pc[XLEN-1:IDX_W+2];
   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_comb begin
      wr_en       = 1'b0;
      wr_target_d = target_q[wr_idx];
      wr_jump_d   = jump_q[wr_idx];
      wr_cnt_d    = cnt_q[wr_idx];
      if (upd_valid) begin
         if (wr_hit) begin
            wr_en = 1'b1;
            if (upd_is_jump) begin
               wr_cnt_d    = CNT_ST;
               wr_target_d = upd_target;
               wr_jump_d   = 1'b1;
            end else if (upd_taken) begin
               wr_cnt_d    = (cnt_q[wr_idx] == CNT_ST) ? CNT_ST : cnt_q[wr_idx] + 2'd1;
               wr_target_d = upd_target;
            end else begin
               wr_cnt_d    = (cnt_q[wr_idx] == CNT_SNT) ? CNT_SNT : cnt_q[wr_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Allocation evicts whatever currently lives at this index.
            wr_en       = 1'b1;
            wr_target_d = upd_target;
            wr_jump_d   = upd_is_jump;
            wr_cnt_d    = upd_is_jump ? CNT_ST : CNT_WT;
         end
      end
   end

   // The reset branch wins on any edge where rst is high, so no write leaks through.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q[gi]  <= 1'b0;
               tag_q[gi]    <= '0;
               target_q[gi] <= '0;
               jump_q[gi]   <= 1'b0;
               cnt_q[gi]    <= CNT_WNT;
            end else if (wr_en && (wr_idx == ENTRY_IDX)) begin
               valid_q[gi]  <= 1'b1;
               tag_q[gi]    <= wr_tag;
               target_q[gi] <= wr_target_d;
               jump_q[gi]   <= wr_jump_d;
               cnt_q[gi]    <= wr_cnt_d;
            end
         end
      end
   endgenerate

   // ---------------- misprediction / redirect ----------------
   logic            mispredict_raw;
   logic [XLEN-1:0] redirect_raw;

   assign mispredict_raw = upd_valid &&
                           ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target)));
   assign redirect_raw   = upd_taken ? upd_target : upd_pc + XLEN'(4);
   assign mispredict     = mispredict_raw && !rst;
   assign redirect_pc    = (upd_valid && !rst) ? redirect_raw : '0;

`ifdef BP_STATS_EN
   logic [31:0] stat_updates_q;
   logic [31:0] stat_mispredicts_q;
   logic [31:0] stat_updates_d;
   logic [31:0] stat_mispredicts_d;

   assign stat_updates_d     = stat_updates_q + (upd_valid ? 32'd1 : 32'd0);
   assign stat_mispredicts_d = stat_mispredicts_q + (mispredict_raw ? 32'd1 : 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_updates_q     <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_updates_q     <= stat_updates_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_updates     = stat_updates_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; a negedge monitor checks the expectation queue.
module tb_branch_predictor;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rst_v = 1'b1;
   logic [XLEN-1:0] if_pc = '0;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid = 1'b0;
   logic [XLEN-1:0] upd_pc = '0;
   logic            upd_is_jump = 1'b0;
   logic            upd_taken = 1'b0;
   logic [XLEN-1:0] upd_target = '0;
   logic            upd_pred_taken = 1'b0;
   logic [XLEN-1:0] upd_pred_target = '0;
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;
`ifdef BP_STATS_EN
   logic [31:0]     stat_updates;
   logic [31:0]     stat_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_predictor #(.IDX_W(4), .XLEN(XLEN)) dut (
      .clk             (clk),
      .rst             (rst),
      .if_pc           (if_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_jump     (upd_is_jump),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
      ,
      .stat_updates    (stat_updates),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   typedef struct {
      string       name;
      int          cyc;
      logic        pt;
      logic [31:0] tgt;
      logic        mp;
      logic [31:0] rd;
      logic        st;
      logic [31:0] su;
      logic [31:0] sm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic drain = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                        input logic j, input logic t, input logic [31:0] tg,
                        input logic ppt, input logic [31:0] ptg);
      @(posedge clk);
      #1;
      rst             = rst_v;
      if_pc           = ipc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_is_jump     = j;
      upd_taken       = t;
      upd_target      = tg;
      upd_pred_taken  = ppt;
      upd_pred_target = ptg;
   endtask

   task automatic idle(input logic [31:0] ipc);
      drive(ipc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic push_exp(input string nm, input logic pt, input logic [31:0] tgt,
                           input logic mp, input logic [31:0] rd);
      exp_t e;
      e.name = nm; e.cyc = cyc; e.pt = pt; e.tgt = tgt; e.mp = mp; e.rd = rd;
      e.st = 1'b0; e.su = '0; e.sm = '0;
      sb.push_back(e);
   endtask

   task automatic push_exp_st(input string nm, input logic pt, input logic [31:0] tgt,
                              input logic mp, input logic [31:0] rd,
                              input logic [31:0] su, input logic [31:0] sm);
      exp_t e;
      e.name = nm; e.cyc = cyc; e.pt = pt; e.tgt = tgt; e.mp = mp; e.rd = rd;
      e.st = 1'b1; e.su = su; e.sm = sm;
      sb.push_back(e);
   endtask

   // Monitor: pops every expectation due this cycle and compares against live outputs.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            checks++; failures++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
         end else begin
            checks++;
            if (pred_taken !== e.pt) begin
               failures++;
               $display("FAIL %s pred_taken: got %0b expected %0b", e.name, pred_taken, e.pt);
            end
            checks++;
            if (pred_target !== e.tgt) begin
               failures++;
               $display("FAIL %s pred_target: got %h expected %h", e.name, pred_target, e.tgt);
            end
            checks++;
            if (mispredict !== e.mp) begin
               failures++;
               $display("FAIL %s mispredict: got %0b expected %0b", e.name, mispredict, e.mp);
            end
            checks++;
            if (redirect_pc !== e.rd) begin
               failures++;
               $display("FAIL %s redirect_pc: got %h expected %h", e.name, redirect_pc, e.rd);
            end
`ifdef BP_STATS_EN
            if (e.st) begin
               checks++;
               if (stat_updates !== e.su) begin
                  failures++;
                  $display("FAIL %s stat_updates: got %0d expected %0d", e.name, stat_updates, e.su);
               end
               checks++;
               if (stat_mispredicts !== e.sm) begin
                  failures++;
                  $display("FAIL %s stat_mispredicts: got %0d expected %0d", e.name, stat_mispredicts, e.sm);
               end
            end
`endif
            $display("txn %-18s if_pc=%h pred_taken=%0b pred_target=%h mispredict=%0b redirect_pc=%h",
                     e.name, if_pc, pred_taken, pred_target, mispredict, redirect_pc);
         end
      end
      if (drain && sb.size() > 0) begin
         e = sb.pop_front();
         checks++; failures++;
         $display("FAIL %s: expectation left unchecked", e.name);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Held in reset: update is gated, nothing may be written.
      rst_v = 1'b1;
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
      push_exp("rst_gate", 1'b0, 32'h0, 1'b0, 32'h0);
      idle(32'h0);
      push_exp("rst_idle", 1'b0, 32'h0, 1'b0, 32'h0);
      rst_v = 1'b0;
      idle(32'h40);
      push_exp("post_rst_40", 1'b0, 32'h0, 1'b0, 32'h0);
      idle(32'h0);
      push_exp("post_rst_0", 1'b0, 32'h0, 1'b0, 32'h0);

      // First taken branch: allocate cnt=10, lookup sees old contents this cycle.
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
      push_exp("alloc_same_cyc", 1'b0, 32'h0, 1'b1, 32'h10);
      idle(32'h40);
      push_exp("alloc_visible", 1'b1, 32'h10, 1'b0, 32'h0);

      // Hysteresis: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10);
      push_exp("correct_pred_a", 1'b1, 32'h10, 1'b0, 32'h10);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10);
      push_exp("correct_pred_b", 1'b1, 32'h10, 1'b0, 32'h10);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
      push_exp("nt_mp_1", 1'b1, 32'h10, 1'b1, 32'h44);
      idle(32'h40);
      push_exp("hyst_still_taken", 1'b1, 32'h10, 1'b0, 32'h0);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
      push_exp("nt_mp_2", 1'b1, 32'h10, 1'b1, 32'h44);
      idle(32'h40);
      push_exp("hyst_now_nt", 1'b0, 32'h0, 1'b0, 32'h0);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp("nt_to_00", 1'b0, 32'h0, 1'b0, 32'h44);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp("nt_hold_00", 1'b0, 32'h0, 1'b0, 32'h44);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
      push_exp("t_from_00", 1'b0, 32'h0, 1'b1, 32'h10);
      idle(32'h40);
      push_exp("sat_floor", 1'b0, 32'h0, 1'b0, 32'h0);
      drive(32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
      push_exp("t_to_10", 1'b0, 32'h0, 1'b1, 32'h10);
      idle(32'h40);
      push_exp("taken_again", 1'b1, 32'h10, 1'b0, 32'h0);

      // Aliasing at index 0: 0x80 must not hit on 0x40's entry, then evicts it.
      idle(32'h80);
      push_exp("alias_miss", 1'b0, 32'h0, 1'b0, 32'h0);
      drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      push_exp("jump_alloc", 1'b0, 32'h0, 1'b1, 32'h200);
      idle(32'h80);
      push_exp("jump_hit", 1'b1, 32'h200, 1'b0, 32'h0);
      idle(32'h40);
      push_exp("evicted", 1'b0, 32'h0, 1'b0, 32'h0);

      // Miss, not taken: no allocation.
      drive(32'h44, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp("miss_nt", 1'b0, 32'h0, 1'b0, 32'h48);
      idle(32'h44);
      push_exp("miss_nt_no_alloc", 1'b0, 32'h0, 1'b0, 32'h0);

      // Fall-through wraps to 0; target-only mispredict on a jump.
      drive(32'h80, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
      push_exp("wrap", 1'b1, 32'h200, 1'b1, 32'h0);
      drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
      push_exp("target_mp", 1'b1, 32'h200, 1'b1, 32'h300);
      idle(32'h80);
      push_exp("jump_retarget", 1'b1, 32'h300, 1'b0, 32'h0);
      drive(32'h80, 1'b1, 32'h48, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500);
      push_exp("alloc_idx2", 1'b1, 32'h300, 1'b0, 32'h500);
      idle(32'h48);
      push_exp_st("idx2_hit", 1'b1, 32'h500, 1'b0, 32'h0, 32'd14, 32'd8);

      // Mid-run reset: table clears immediately, pending update discarded.
      rst_v = 1'b1;
      drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
      push_exp("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
      rst_v = 1'b0;
      idle(32'h80);
      push_exp_st("rst_mid_80", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0);
      idle(32'h48);
      push_exp("rst_mid_48", 1'b0, 32'h0, 1'b0, 32'h0);
      idle(32'h40);
      push_exp("rst_mid_40", 1'b0, 32'h0, 1'b0, 32'h0);

      @(posedge clk);
      #1;
      drain = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
